// File: rtl/llm_staged_if.sv
// Signal bundle for llm_staged: advance/threat/hold controls and stage thresholds in,
// registered state-machine status out.
interface llm_staged_if #(
  parameter int NUM_STAGES = 3,
  parameter int TIMER_W    = 8
);
  logic                          green;
  logic                          red;
  logic                          yellow;
  logic [NUM_STAGES*TIMER_W-1:0] stage_time;
  logic [NUM_STAGES-1:0]         attack;
  logic                          deception_out;
  logic [3:0]                    current_state;
  logic [2:0]                    stage_idx;
  logic [TIMER_W-1:0]            timer;
  logic [3:0]                    retry_cnt;
  logic                          done;
  logic                          failed;

  modport master (
    output green, red, yellow, stage_time,
    input  attack, deception_out, current_state, stage_idx, timer, retry_cnt, done, failed
  );

  modport slave (
    input  green, red, yellow, stage_time,
    output attack, deception_out, current_state, stage_idx, timer, retry_cnt, done, failed
  );
endinterface

// File: rtl/llm_staged.sv
// Staged attack controller: lay low, climb through NUM_STAGES timed attack stages,
// fall back to deception on threat; terminal FAIL and EXPANSION states.
module llm_staged #(
  parameter int NUM_STAGES   = 3,
  parameter int TIMER_W      = 8,
  parameter int LAY_LOW_TIME = 20,
  parameter int MAX_RETRY    = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  llm_staged_if.slave   bus
);

  typedef enum logic [3:0] {
    S_LAY_LOW   = 4'd0,
    S_DECEPTION = 4'd1,
    S_ATTACK    = 4'd2,
    S_FAIL      = 4'd4,
    S_EXPANSION = 4'd5
  } state_e;

  localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] LAY_THR   = TIMER_W'(LAY_LOW_TIME);
  localparam logic [3:0]         RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [2:0]         LAST_STG  = 3'(NUM_STAGES - 1);

  state_e                  state_q, state_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [2:0]              stage_q, stage_d;
  logic [NUM_STAGES-1:0]   attack_q, attack_d;
  logic                    dec_q, dec_d;
  logic [3:0]              retry_q, retry_d;
  logic                    done_q, done_d;
  logic                    failed_q, failed_d;

  logic [TIMER_W-1:0]      thr_sel;
  logic [TIMER_W-1:0]      stage_thr;
  logic [TIMER_W-1:0]      timer_inc;
  logic [3:0]              retry_inc;

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  // Thermometer with the lowest n bits set.
  function automatic logic [NUM_STAGES-1:0] therm(input logic [3:0] n);
    logic [NUM_STAGES-1:0] r;
    for (int i = 0; i < NUM_STAGES; i++) r[i] = (4'(i) < n);
    return r;
  endfunction

  always_comb begin
    thr_sel = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_q == 3'(i)) thr_sel = bus.stage_time[i*TIMER_W +: TIMER_W];
    end
  end

  // A zero threshold still costs one cycle in the stage.
  assign stage_thr = (thr_sel == '0) ? T_ONE : thr_sel;
  assign timer_inc = sat_inc(timer_q);
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stage_d  = stage_q;
    attack_d = attack_q;
    dec_d    = dec_q;
    retry_d  = retry_q;
    done_d   = done_q;
    failed_d = failed_q;

    case (state_q)
      S_LAY_LOW: begin
        if (bus.red) begin
          state_d = S_DECEPTION;
          dec_d   = 1'b1;
          timer_d = T_ONE;
          retry_d = '0;
        end else if (bus.green && timer_q >= LAY_THR) begin
          state_d  = S_ATTACK;
          stage_d  = '0;
          attack_d = therm(4'd1);
          timer_d  = T_ONE;
        end else if (!bus.yellow) begin
          timer_d = timer_inc;
        end
      end

      S_ATTACK: begin
        if (bus.red) begin
          state_d  = S_DECEPTION;
          attack_d = '0;
          dec_d    = 1'b1;
          timer_d  = T_ONE;
          retry_d  = '0;
        end else if (bus.green && timer_q >= stage_thr) begin
          timer_d = T_ONE;
          if (stage_q != LAST_STG) begin
            stage_d  = stage_q + 3'd1;
            attack_d = therm({1'b0, stage_q} + 4'd2);
          end else begin
            state_d  = S_EXPANSION;
            attack_d = '1;
            done_d   = 1'b1;
          end
        end else if (!bus.yellow) begin
          timer_d = timer_inc;
        end
      end

      // Entry cycle is the minimum dwell; red is judged from the next cycle on.
      S_DECEPTION: begin
        if (bus.red) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_LIM) begin
            state_d  = S_FAIL;
            failed_d = 1'b1;
            dec_d    = 1'b0;
            attack_d = '0;
            timer_d  = T_ONE;
          end
        end else begin
          state_d = S_LAY_LOW;
          dec_d   = 1'b0;
          timer_d = T_ONE;
          stage_d = '0;
          retry_d = '0;
        end
      end

      S_FAIL: begin
        timer_d = T_ONE;
      end

      S_EXPANSION: begin
        timer_d = timer_inc;
      end

      default: begin
        state_d  = S_LAY_LOW;
        timer_d  = T_ONE;
        stage_d  = '0;
        attack_d = '0;
        dec_d    = 1'b0;
        retry_d  = '0;
        done_d   = 1'b0;
        failed_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_LAY_LOW;
      timer_q  <= T_ONE;
      stage_q  <= '0;
      attack_q <= '0;
      dec_q    <= 1'b0;
      retry_q  <= '0;
      done_q   <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stage_q  <= stage_d;
      attack_q <= attack_d;
      dec_q    <= dec_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      failed_q <= failed_d;
    end
  end

  assign bus.current_state = state_q;
  assign bus.timer         = timer_q;
  assign bus.stage_idx     = stage_q;
  assign bus.attack        = attack_q;
  assign bus.deception_out = dec_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.done          = done_q;
  assign bus.failed        = failed_q;

endmodule

// File: tb/tb_llm_staged.sv
// Directed bench for llm_staged: default build plus a narrow-timer, two-stage,
// single-retry build sharing one clock and reset.
module tb_llm_staged;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  llm_staged_if #(.NUM_STAGES(3), .TIMER_W(8)) bus ();
  llm_staged_if #(.NUM_STAGES(2), .TIMER_W(4)) bus4 ();

  llm_staged #(.NUM_STAGES(3), .TIMER_W(8), .LAY_LOW_TIME(20), .MAX_RETRY(2)) u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  llm_staged #(.NUM_STAGES(2), .TIMER_W(4), .LAY_LOW_TIME(3), .MAX_RETRY(1)) u_dut4 (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_main(input string tag);
    chk({tag, ".state"},  32'(bus.current_state), 0);
    chk({tag, ".timer"},  32'(bus.timer),         1);
    chk({tag, ".stage"},  32'(bus.stage_idx),     0);
    chk({tag, ".attack"}, 32'(bus.attack),        0);
    chk({tag, ".dec"},    32'(bus.deception_out), 0);
    chk({tag, ".retry"},  32'(bus.retry_cnt),     0);
    chk({tag, ".done"},   32'(bus.done),          0);
    chk({tag, ".failed"}, 32'(bus.failed),        0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.green  = 1'b0; bus.red  = 1'b0; bus.yellow  = 1'b0;
    bus4.green = 1'b0; bus4.red = 1'b0; bus4.yellow = 1'b0;
    bus.stage_time  = {8'd10, 8'd20, 8'd20};
    bus4.stage_time = {4'd0, 4'd2};
    #2;

    // Full climb to EXPANSION
    do_reset();
    chk_reset_main("rst");
    bus.green = 1'b1;
    tick(19);
    chk("ll.t20.state", 32'(bus.current_state), 0);
    chk("ll.t20.timer", 32'(bus.timer), 20);
    tick(1);
    chk("s0.state",  32'(bus.current_state), 2);
    chk("s0.attack", 32'(bus.attack), 32'b001);
    chk("s0.timer",  32'(bus.timer), 1);
    tick(20);
    chk("s1.stage",  32'(bus.stage_idx), 1);
    chk("s1.attack", 32'(bus.attack), 32'b011);
    tick(19);
    chk("s1.t20", 32'(bus.timer), 20);
    tick(1);
    chk("s2.stage",  32'(bus.stage_idx), 2);
    chk("s2.attack", 32'(bus.attack), 32'b111);
    tick(9);
    chk("s2.t10.state", 32'(bus.current_state), 2);
    tick(1);
    chk("exp.state",  32'(bus.current_state), 5);
    chk("exp.done",   32'(bus.done), 1);
    chk("exp.attack", 32'(bus.attack), 32'b111);
    chk("exp.timer",  32'(bus.timer), 1);
    tick(3);
    chk("exp.count", 32'(bus.timer), 4);

    // Brief red in stage 1, then back to LAY_LOW
    do_reset();
    bus.green = 1'b1;
    tick(40);
    chk("r1.stage", 32'(bus.stage_idx), 1);
    tick(3);
    bus.red = 1'b1;
    tick(1);
    chk("r1.dec.state",  32'(bus.current_state), 1);
    chk("r1.dec.attack", 32'(bus.attack), 0);
    chk("r1.dec.out",    32'(bus.deception_out), 1);
    chk("r1.dec.timer",  32'(bus.timer), 1);
    bus.red = 1'b0;
    tick(1);
    chk("r1.ll.state", 32'(bus.current_state), 0);
    chk("r1.ll.timer", 32'(bus.timer), 1);
    chk("r1.ll.retry", 32'(bus.retry_cnt), 0);
    chk("r1.ll.dec",   32'(bus.deception_out), 0);
    chk("r1.ll.stage", 32'(bus.stage_idx), 0);

    // Red held from stage 0 until FAIL
    do_reset();
    bus.green = 1'b1;
    tick(20);
    chk("rf.s0", 32'(bus.current_state), 2);
    bus.red = 1'b1;
    tick(1);
    chk("rf.dec.retry0", 32'(bus.retry_cnt), 0);
    tick(1);
    chk("rf.dec.state", 32'(bus.current_state), 1);
    chk("rf.dec.retry1", 32'(bus.retry_cnt), 1);
    tick(1);
    chk("rf.fail.state",  32'(bus.current_state), 4);
    chk("rf.fail.failed", 32'(bus.failed), 1);
    chk("rf.fail.timer",  32'(bus.timer), 1);
    chk("rf.fail.dec",    32'(bus.deception_out), 0);
    bus.red = 1'b0;
    tick(3);
    chk("rf.fail.hold",  32'(bus.current_state), 4);
    chk("rf.fail.timer2", 32'(bus.timer), 1);

    // Yellow freezes the LAY_LOW timer for 5 cycles
    do_reset();
    bus.green = 1'b1;
    tick(10);
    bus.yellow = 1'b1;
    tick(5);
    chk("y.frozen", 32'(bus.timer), 11);
    bus.yellow = 1'b0;
    tick(9);
    chk("y.t20.state", 32'(bus.current_state), 0);
    chk("y.t20.timer", 32'(bus.timer), 20);
    tick(1);
    chk("y.attack", 32'(bus.current_state), 2);

    // Red beats green at the LAY_LOW threshold
    do_reset();
    bus.green = 1'b0;
    tick(19);
    chk("rg.timer", 32'(bus.timer), 20);
    bus.green = 1'b1;
    bus.red   = 1'b1;
    tick(1);
    chk("rg.state",  32'(bus.current_state), 1);
    chk("rg.attack", 32'(bus.attack), 0);
    bus.red   = 1'b0;
    bus.green = 1'b0;

    // Asynchronous reset in stage 2
    do_reset();
    bus.green = 1'b1;
    tick(63);
    chk("ar.pre.stage", 32'(bus.stage_idx), 2);
    rst_n = 1'b0;
    #2;
    chk_reset_main("ar");
    @(posedge clk);
    #1;
    chk("ar.held.state", 32'(bus.current_state), 0);
    chk("ar.held.timer", 32'(bus.timer), 1);
    rst_n = 1'b1;
    bus.green = 1'b0;

    // Narrow build: climb to EXPANSION and saturate the timer
    do_reset();
    bus4.green = 1'b1;
    tick(3);
    chk("n.s0.state", 32'(bus4.current_state), 2);
    tick(2);
    chk("n.s1.attack", 32'(bus4.attack), 32'b11);
    tick(1);
    chk("n.exp.state", 32'(bus4.current_state), 5);
    chk("n.exp.done",  32'(bus4.done), 1);
    tick(14);
    chk("n.sat15", 32'(bus4.timer), 15);
    tick(5);
    chk("n.sat.hold", 32'(bus4.timer), 15);

    // Narrow build: single red reaches FAIL, reset clears it asynchronously
    do_reset();
    bus4.green = 1'b0;
    bus4.red   = 1'b1;
    tick(1);
    chk("n.dec", 32'(bus4.current_state), 1);
    tick(1);
    chk("n.fail.state",  32'(bus4.current_state), 4);
    chk("n.fail.failed", 32'(bus4.failed), 1);
    bus4.red = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("n.rst.failed", 32'(bus4.failed), 0);
    chk("n.rst.state",  32'(bus4.current_state), 0);
    #5;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/llm_staged.md
LLM_STAGED -- requirements
Module: llm_staged

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of attack stages (range 1..8).
REQ-002 SHALL have parameter TIMER_W, default 8, width of the timer and of each stage threshold.
REQ-003 SHALL have parameter LAY_LOW_TIME, default 20, LAY_LOW dwell threshold in cycles.
REQ-004 SHALL have parameter MAX_RETRY, default 2, consecutive red cycles tolerated in DECEPTION before FAIL (range 1..15).
REQ-005 SHALL have port clock  input  1  single rising-edge clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports green, red, yellow  input  1 each  advance, threat, hold.
REQ-008 SHALL have port stage_time  input  NUM_STAGES*TIMER_W  threshold for stage k in bits [k*TIMER_W +: TIMER_W].
REQ-009 SHALL have port attack  output  NUM_STAGES  thermometer of stages reached.
REQ-010 SHALL have port deception_out  output  1  high while in DECEPTION.
REQ-011 SHALL have port current_state  output  4  encoding LAY_LOW=0, DECEPTION=1, ATTACK=2, FAIL=4, EXPANSION=5.
REQ-012 SHALL have port stage_idx  output  3  active attack stage index.
REQ-013 SHALL have port timer  output  TIMER_W  cycles in current state, starting at 1.
REQ-014 SHALL have port retry_cnt  output  4  red cycles counted in the current DECEPTION visit.
REQ-015 SHALL have ports done, failed  output  1 each  high in EXPANSION and FAIL respectively.

Function
REQ-016 SHALL register all outputs and update them only on the rising edge of clock, except on reset.
REQ-017 SHALL give red highest priority in every state, so red with green takes the red path.
REQ-018 SHALL hold timer unchanged while yellow=1 in LAY_LOW or ATTACK; transitions are still evaluated against the held value.
REQ-019 SHALL otherwise increment timer by 1 per cycle in LAY_LOW, ATTACK and EXPANSION, saturating at all-ones with no wrap.
REQ-020 SHALL, in LAY_LOW: on red go to DECEPTION with deception_out=1 and timer=1.
REQ-021 SHALL, in LAY_LOW: else on green with timer>=LAY_LOW_TIME go to ATTACK with stage_idx=0, attack[0]=1, timer=1.
REQ-022 SHALL, in ATTACK stage k: on red go to DECEPTION, clear all attack bits, set deception_out=1 and timer=1.
REQ-023 SHALL, in ATTACK stage k: else on green with timer>=max(stage_time[k],1) either go to stage k+1 (attack[k+1]=1, timer=1) if k<NUM_STAGES-1, or go to EXPANSION (done=1, timer=1).
REQ-024 SHALL, in DECEPTION with red=1: increment retry_cnt; when the incremented value equals MAX_RETRY go to FAIL, else remain in DECEPTION.
REQ-025 SHALL, in DECEPTION with red=0: go to LAY_LOW with deception_out=0, timer=1, stage_idx=0, retry_cnt=0.
REQ-026 SHALL treat the first DECEPTION cycle as minimum dwell, evaluating red from the cycle after entry.
REQ-027 SHALL make FAIL terminal: failed=1, deception_out=0, attack=0, timer held at 1, all inputs ignored.
REQ-028 SHALL make EXPANSION terminal: attack all ones, done=1, timer counting and saturating, inputs ignored.
REQ-029 SHALL sample stage_time each cycle, so changing it mid-stage takes effect on the next compare.
REQ-030 SHALL go to LAY_LOW with reset values on any unused current_state encoding at the next clock.
REQ-031 SHALL, with NUM_STAGES=3 and MAX_RETRY=1, match the single-red-to-FAIL sequence of the three-stage predecessor, except that the >= compare cannot miss a threshold.

Reset
REQ-032 SHALL, on reset_n=0 and independent of clock, set current_state=LAY_LOW, timer=1, stage_idx=0, attack=0, deception_out=0, retry_cnt=0, done=0, failed=0.
REQ-033 SHALL, while reset_n=0, keep all outputs at those values, including when asserted mid-stage or in FAIL or EXPANSION.
REQ-034 SHALL make the first state update on the first rising clock after reset_n rises.

Verification
REQ-035 SHALL check: defaults, stage_time={10,20,20}, green held -> ATTACK at timer 20, stages 0/1/2 at 20/20/10 cycles, EXPANSION with attack=3'b111 and done=1.
REQ-036 SHALL check: red in stage 1 for 1 cycle, then red=0 -> DECEPTION (attack=0, deception_out=1), then LAY_LOW with timer=1 and retry_cnt=0.
REQ-037 SHALL check: MAX_RETRY=2, red held from stage 0 -> DECEPTION, retry_cnt=1, then FAIL with failed=1 and timer=1.
REQ-038 SHALL check: yellow=1 for 5 cycles in LAY_LOW -> timer frozen, ATTACK entry delayed exactly 5 cycles.
REQ-039 SHALL check: green=red=1 at timer=20 in LAY_LOW -> DECEPTION, not ATTACK.
REQ-040 SHALL check: reset_n low between clock edges in stage 2 -> all outputs return to reset values immediately; TIMER_W=4 in EXPANSION -> timer saturates at 15.
